// File: rtl/inst_mem_loadable.sv
// Instruction memory with a registered, stall-aware fetch port and a streaming program-load port.
// Optional per-word even parity with a parity_err output when INST_MEM_PARITY_EN is defined.
//
// state   | meaning
// IDLE    | fetch port live, load port ignores load_valid
// LOADING | loader owns the array, fetch requests are dropped
module inst_mem_loadable #(
    parameter int                  WORD_LEN    = 32,
    parameter int                  ADDRESS_LEN = 32,
    parameter longint unsigned     DEPTH       = 1024,
    parameter logic [WORD_LEN-1:0] NOP_WORD    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fetch_req,
    input  logic [ADDRESS_LEN-1:0] adr,
    input  logic                   stall,
    output logic [WORD_LEN-1:0]    inst,
    output logic                   inst_valid,
    output logic                   fetch_oor,
    output logic                   busy,
    input  logic                   load_start,
    input  logic [ADDRESS_LEN-1:0] load_base,
    input  logic                   load_valid,
    input  logic [WORD_LEN-1:0]    load_data,
    input  logic                   load_done,
    output logic                   load_ovf,
    output logic [ADDRESS_LEN-1:0] load_count
`ifdef INST_MEM_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so the pointer can sit at DEPTH without wrapping.
    localparam logic [ADDRESS_LEN:0] DEPTH_W = (ADDRESS_LEN+1)'(DEPTH);
`ifdef INST_MEM_PARITY_EN
    localparam int MEM_W = WORD_LEN + 1;
`else
    localparam int MEM_W = WORD_LEN;
`endif

    typedef enum logic {IDLE, LOADING} state_t;

    state_t                 state_q, state_d;
    logic [ADDRESS_LEN:0]   ptr_q;
    logic                   ptr_in_range;
    logic                   adr_in_range;
    logic                   wr_en;
    logic                   fetch_en;
    logic [MEM_W-1:0]       wr_word;
    logic [MEM_W-1:0]       rd_word;
    logic [MEM_W-1:0]       mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        busy     = (state_q == LOADING);
        fetch_en = (state_q == IDLE) && fetch_req;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) state_d = LOADING;
            end
            LOADING: begin
                // A restart takes precedence over the word presented in the same cycle.
                wr_en = !rst && !load_start && load_valid && ptr_in_range;
                if (load_start)     state_d = LOADING;
                else if (load_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ptr_in_range = (ptr_q < DEPTH_W);
    assign adr_in_range = ({1'b0, adr} < DEPTH_W);

`ifdef INST_MEM_PARITY_EN
    assign wr_word = {^load_data, load_data};
`else
    assign wr_word = load_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            load_count <= '0;
            load_ovf   <= 1'b0;
        end else if (load_start) begin
            ptr_q      <= {1'b0, load_base};
            load_count <= '0;
            load_ovf   <= 1'b0;
        end else if (state_q == LOADING && load_valid) begin
            if (ptr_in_range) begin
                ptr_q      <= ptr_q + 1'b1;
                load_count <= load_count + 1'b1;
            end else begin
                load_ovf   <= 1'b1;
            end
        end
    end

    // Array has no reset so a reset mid-load keeps the words already written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr_q[AW-1:0]] <= wr_word;
    end

    assign rd_word = mem[adr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            inst       <= '0;
            inst_valid <= 1'b0;
            fetch_oor  <= 1'b0;
`ifdef INST_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (!stall) begin
            if (fetch_en) begin
                inst_valid <= 1'b1;
                if (adr_in_range) begin
                    inst      <= rd_word[WORD_LEN-1:0];
                    fetch_oor <= 1'b0;
`ifdef INST_MEM_PARITY_EN
                    parity_err <= ^rd_word;
`endif
                end else begin
                    inst      <= NOP_WORD;
                    fetch_oor <= 1'b1;
`ifdef INST_MEM_PARITY_EN
                    parity_err <= 1'b0;
`endif
                end
            end else begin
                inst_valid <= 1'b0;
`ifdef INST_MEM_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
        end
    end

`ifdef INST_MEM_PARITY_EN
    // Simulation hook: corrupt one stored data bit while leaving its parity bit alone.
    task automatic force_bit_flip(input logic [ADDRESS_LEN-1:0] addr, input int bit_idx);
        mem[addr[AW-1:0]][bit_idx] <= ~mem[addr[AW-1:0]][bit_idx];
    endtask
`endif

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Randomised self-checking bench for inst_mem_loadable against an array/queue reference model.
module tb_inst_mem_loadable;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] adr = '0;
    logic        stall = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_oor;
    logic        busy;
    logic        load_start = 1'b0;
    logic [31:0] load_base = '0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_done = 1'b0;
    logic        load_ovf;
    logic [31:0] load_count;
`ifdef INST_MEM_PARITY_EN
    logic        parity_err;
`endif

    inst_mem_loadable dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .adr(adr), .stall(stall),
        .inst(inst), .inst_valid(inst_valid), .fetch_oor(fetch_oor), .busy(busy),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_data(load_data), .load_done(load_done), .load_ovf(load_ovf),
        .load_count(load_count)
`ifdef INST_MEM_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [31:0] model [DEPTH];
    bit          written [DEPTH];
    int          wr_addrs[$];
    int          exp_count;
    bit          exp_ovf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Streams words from base; the model follows the plain rule "address < DEPTH is written".
    task automatic stream_load(input int base, input logic [31:0] words[$],
                               input bit gaps, input bit done_with_last);
        exp_count = 0;
        exp_ovf   = 1'b0;
        load_start = 1'b1;
        load_base  = base;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < words.size(); i++) begin
            if (gaps && $urandom_range(0, 1) == 1) tick();
            load_valid = 1'b1;
            load_data  = words[i];
            load_done  = done_with_last && (i == words.size() - 1);
            if (base + i < DEPTH) begin
                model[base + i] = words[i];
                if (!written[base + i]) wr_addrs.push_back(base + i);
                written[base + i] = 1'b1;
                exp_count++;
            end else begin
                exp_ovf = 1'b1;
            end
            tick();
            load_valid = 1'b0;
        end
        if (!done_with_last) begin
            load_done = 1'b1;
            tick();
        end
        load_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (inst !== 32'h0) $display("FAIL reset_inst got=%h exp=0", inst); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", inst_valid); else passed++;
        total++; if (fetch_oor !== 1'b0) $display("FAIL reset_oor got=%b exp=0", fetch_oor); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (load_ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", load_ovf); else passed++;
        total++; if (load_count !== 32'd0) $display("FAIL reset_count got=%0d exp=0", load_count); else passed++;
    endtask

    task automatic test_load_fetch();
        logic [31:0] w[$] = '{32'h8C010020, 32'h8C100021, 32'h00001024};
        stream_load(100, w, 1'b0, 1'b0);
        total++; if (load_count !== 32'd3) $display("FAIL lf_count got=%0d exp=3", load_count); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL lf_busy got=%b exp=0", busy); else passed++;
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adr = 100 + i;
            tick();
            total++;
            if (inst !== w[i] || inst_valid !== 1'b1 || fetch_oor !== 1'b0)
                $display("FAIL lf_fetch adr=%0d got=%h/%b/%b exp=%h/1/0", 100 + i, inst, inst_valid, fetch_oor, w[i]);
            else passed++;
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        fetch_req = 1'b1;
        adr = 100;
        tick();
        stall = 1'b1;
        adr = 101;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (inst !== 32'h8C010020 || inst_valid !== 1'b1)
                $display("FAIL stall_hold cyc=%0d got=%h/%b exp=8c010020/1", i, inst, inst_valid);
            else passed++;
        end
        stall = 1'b0;
        tick();
        total++; if (inst !== 32'h8C100021) $display("FAIL stall_release got=%h exp=8c100021", inst); else passed++;
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_oor_busy();
        fetch_req = 1'b1;
        adr = DEPTH;
        tick();
        total++;
        if (inst !== 32'h0 || fetch_oor !== 1'b1 || inst_valid !== 1'b1)
            $display("FAIL oor got=%h/%b/%b exp=0/1/1", inst, fetch_oor, inst_valid);
        else passed++;
        adr = 100;
        tick();
        fetch_req = 1'b0;
        load_start = 1'b1;
        load_base = 500;
        tick();
        load_start = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL busy_loading got=%b exp=1", busy); else passed++;
        fetch_req = 1'b1;
        adr = 101;
        tick();
        total++;
        if (inst_valid !== 1'b0 || inst !== 32'h8C010020)
            $display("FAIL fetch_while_busy got=%h/%b exp=8c010020/0", inst, inst_valid);
        else passed++;
        fetch_req = 1'b0;
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL busy_after_done got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_overflow();
        logic [31:0] w[$] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4};
        logic [31:0] none[$];
        stream_load(1022, w, 1'b0, 1'b0);
        total++; if (load_count !== 32'd2) $display("FAIL ovf_count got=%0d exp=2", load_count); else passed++;
        total++; if (load_ovf !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", load_ovf); else passed++;
        fetch_req = 1'b1;
        adr = 1022; tick();
        total++; if (inst !== 32'hA1A1A1A1) $display("FAIL ovf_1022 got=%h exp=a1a1a1a1", inst); else passed++;
        adr = 1023; tick();
        total++; if (inst !== 32'hB2B2B2B2) $display("FAIL ovf_1023 got=%h exp=b2b2b2b2", inst); else passed++;
        fetch_req = 1'b0;
        tick();
        total++; if (load_ovf !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", load_ovf); else passed++;
        stream_load(0, none, 1'b0, 1'b0);
        total++; if (load_ovf !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", load_ovf); else passed++;
    endtask

    task automatic test_reset_midload();
        logic [31:0] pre[$] = '{32'hDEADBEEF};
        stream_load(12, pre, 1'b0, 1'b0);
        load_start = 1'b1; load_base = 10; tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 32'h11110000; model[10] = load_data; tick();
        load_data = 32'h22220000; model[11] = load_data; tick();
        written[10] = 1'b1; written[11] = 1'b1;
        wr_addrs.push_back(10); wr_addrs.push_back(11);
        load_data = 32'h33330000;
        rst = 1'b1; tick();
        rst = 1'b0; load_valid = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else passed++;
        fetch_req = 1'b1;
        for (int a = 10; a < 13; a++) begin
            adr = a; tick();
            total++;
            if (inst !== model[a]) $display("FAIL rst_mid_word adr=%0d got=%h exp=%h", a, inst, model[a]);
            else passed++;
        end
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_restart();
        load_start = 1'b1; load_base = 10; tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 32'h55550000; model[10] = load_data; tick();
        load_data = 32'h66660000; model[11] = load_data; tick();
        load_valid = 1'b0;
        load_start = 1'b1; load_base = 20; tick();
        load_start = 1'b0;
        total++; if (load_count !== 32'd0) $display("FAIL restart_clear got=%0d exp=0", load_count); else passed++;
        load_valid = 1'b1;
        load_data = 32'h77770000; model[20] = load_data; tick();
        load_valid = 1'b0;
        if (!written[20]) wr_addrs.push_back(20);
        written[20] = 1'b1;
        total++; if (load_count !== 32'd1) $display("FAIL restart_count got=%0d exp=1", load_count); else passed++;
        load_done = 1'b1; tick();
        load_done = 1'b0;
        fetch_req = 1'b1;
        adr = 20; tick();
        total++; if (inst !== 32'h77770000) $display("FAIL restart_word got=%h exp=77770000", inst); else passed++;
        adr = 10; tick();
        total++; if (inst !== 32'h55550000) $display("FAIL restart_old got=%h exp=55550000", inst); else passed++;
        fetch_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        logic [31:0] ei;
        bit          ev, eo;
        int          base, n, a;
        ei = inst; ev = inst_valid; eo = fetch_oor;
        for (int it = 0; it < 20; it++) begin
            w.delete();
            base = ($urandom_range(0, 3) == 0) ? $urandom_range(1018, 1023) : $urandom_range(0, 1023);
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) w.push_back($urandom);
            stream_load(base, w, 1'b1, $urandom_range(0, 1) == 1);
            total++;
            if (load_count !== exp_count || load_ovf !== exp_ovf || busy !== 1'b0)
                $display("FAIL rnd_load base=%0d n=%0d got=%0d/%b/%b exp=%0d/%b/0",
                         base, n, load_count, load_ovf, busy, exp_count, exp_ovf);
            else passed++;
            for (int c = 0; c < 8; c++) begin
                fetch_req = ($urandom_range(0, 3) != 0);
                stall     = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 4) == 0) a = DEPTH + $urandom_range(0, 50);
                else a = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                adr = a;
                if (!stall) begin
                    if (fetch_req) begin
                        ev = 1'b1;
                        if (a < DEPTH) begin ei = model[a]; eo = 1'b0; end
                        else begin ei = 32'h0; eo = 1'b1; end
                    end else ev = 1'b0;
                end
                tick();
                total++;
                if (inst_valid !== ev || inst !== ei || (ev && fetch_oor !== eo))
                    $display("FAIL rnd_fetch adr=%0d got=%h/%b/%b exp=%h/%b/%b",
                             a, inst, inst_valid, fetch_oor, ei, ev, eo);
                else passed++;
            end
            fetch_req = 1'b0;
            stall = 1'b0;
            tick();
            ev = 1'b0;
        end
    endtask

`ifdef INST_MEM_PARITY_EN
    task automatic test_parity();
        logic [31:0] w[$] = '{32'h0000000F, 32'h12345678};
        stream_load(5, w, 1'b0, 1'b0);
        dut.force_bit_flip(32'd5, 0);
        tick();
        fetch_req = 1'b1;
        adr = 5; tick();
        total++; if (parity_err !== 1'b1) $display("FAIL parity_flip got=%b exp=1", parity_err); else passed++;
        adr = 6; tick();
        total++; if (parity_err !== 1'b0) $display("FAIL parity_clean got=%b exp=0", parity_err); else passed++;
        fetch_req = 1'b0;
        tick();
        total++; if (parity_err !== 1'b0) $display("FAIL parity_idle got=%b exp=0", parity_err); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_load_fetch();
        test_stall();
        test_oor_busy();
        test_overflow();
        test_reset_midload();
        test_restart();
        test_random();
`ifdef INST_MEM_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
